// File: rtl/ysyx_25020047_mem_responder.sv
// Word-addressed memory responder with a fixed, parameterised response latency.
// It accepts one request at a time, waits LATENCY cycles, then presents a
// response that is held until the initiator takes it.
module ysyx_25020047_mem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(DEPTH * 4);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wmask_q;
  logic        write_q;
  logic        accept;
  logic        finish;
  logic [31:0] offset;
  logic        in_range;
  logic [AW-1:0] word_idx;

  logic [31:0] mem [DEPTH];

  // The offset wraps for addresses below BASE, so both bounds are checked.
  assign offset   = addr_q - BASE;
  assign in_range = (addr_q >= BASE) && (offset < SPAN);
  assign word_idx = offset[AW+1:2];

  // Next-state logic and handshake outputs; finish marks the single edge where
  // storage is read or written.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          finish     = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; reset returns to IDLE and thereby aborts any transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Request capture and latency countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wmask_q <= 4'd0;
      write_q <= 1'b0;
    end else if (accept) begin
      cnt     <= 4'(LATENCY - 1);
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      wmask_q <= req_wmask;
      write_q <= req_write;
    end else if (state == BUSY && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Response registers, loaded once per transaction and held through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else if (finish) begin
      resp_rdata <= (!write_q && in_range) ? mem[word_idx] : 32'd0;
      resp_err   <= !in_range;
    end
  end

  // Storage is deliberately not reset; only enabled bytes of an in-range store change.
  always_ff @(posedge clk) begin
    if (finish && write_q && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask_q[i]) mem[word_idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25020047_mem_responder.sv
// Self-checking bench for the memory responder: directed vector table,
// hand-written multi-cycle sequences, and random traffic against a word-map model.
module tb_ysyx_25020047_mem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam logic [31:0] SPAN  = 32'(DEPTH * 4);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wmask = '0;
  logic        resp_ready = 1'b0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic        l1_ready_unused, l1_valid, l1_err;
  logic [31:0] l1_rdata_unused;
  logic        l15_ready_unused, l15_valid, l15_err;
  logic [31:0] l15_rdata_unused;

  int compared = 0;
  int mismatched = 0;

  bit [31:0] ref_mem [bit [31:0]];

  typedef struct {
    bit        write;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [3:0]  wmask;
    bit [31:0] exp_rdata;
    bit        exp_err;
  } vec_t;

  vec_t vecs [16];

  always #5 clk = ~clk;

  ysyx_25020047_mem_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wmask(req_wmask), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err));

  ysyx_25020047_mem_responder #(.DEPTH(16), .BASE(BASE), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(l1_ready_unused),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wmask(req_wmask), .resp_valid(l1_valid), .resp_ready(resp_ready),
    .resp_rdata(l1_rdata_unused), .resp_err(l1_err));

  ysyx_25020047_mem_responder #(.DEPTH(16), .BASE(BASE), .LATENCY(15)) dut_l15 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(l15_ready_unused),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wmask(req_wmask), .resp_valid(l15_valid), .resp_ready(resp_ready),
    .resp_rdata(l15_rdata_unused), .resp_err(l15_err));

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic bit modelInRange(input bit [31:0] a);
    bit [63:0] a64;
    a64 = {32'h0, a};
    return (a64 >= {32'h0, BASE}) && (a64 < {32'h0, BASE} + 64'(DEPTH) * 64'd4);
  endfunction

  // Reference behaviour: a map from word address to data, merged byte by byte.
  task automatic modelUpdate(input bit w, input bit [31:0] a, input bit [31:0] d, input bit [3:0] m,
                             output bit [31:0] exp_rdata, output bit exp_err);
    bit [31:0] key;
    bit [31:0] word;
    key = {a[31:2], 2'b00};
    exp_rdata = 32'd0;
    exp_err = 1'b0;
    if (!modelInRange(a)) begin
      exp_err = 1'b1;
    end else if (w) begin
      word = ref_mem.exists(key) ? ref_mem[key] : 32'd0;
      for (int b = 0; b < 4; b++) if (m[b]) word[8*b +: 8] = d[8*b +: 8];
      ref_mem[key] = word;
    end else begin
      exp_rdata = ref_mem[key];
    end
  endtask

  // One full transaction on the main responder: request, latency count, optional hold, handshake.
  task automatic applyStimulus(input bit w, input bit [31:0] a, input bit [31:0] d, input bit [3:0] m,
                               input int hold, output logic [31:0] rdata, output logic err, output int lat);
    int waitc;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_wmask = m;
    waitc = 0;
    while (!req_ready && waitc < 50) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (!req_ready) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept_timeout: got req_ready=0, expected 1");
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_wmask = 4'($urandom);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!resp_valid && lat < 40);
    rdata = resp_rdata;
    err = resp_err;
    repeat (hold) @(posedge clk);
    #1;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rdata;
    logic        err;
    int          lat;
    bit [31:0]   exp_rdata;
    bit          exp_err;
    int          lat1, lat2, lat15, waitc;

    vecs[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, 32'h0,         1'b0};
    vecs[3]  = '{1'b1, 32'h8000_0020, 32'h0000_00AA, 4'h1, 32'h0,         1'b0};
    vecs[4]  = '{1'b1, 32'h8000_0020, 32'h00BB_0000, 4'h4, 32'h0,         1'b0};
    vecs[5]  = '{1'b0, 32'h8000_0020, 32'h0,         4'h0, 32'h11BB_33AA, 1'b0};
    vecs[6]  = '{1'b1, 32'h8000_0FFC, 32'hCAFE_F00D, 4'hF, 32'h0,         1'b0};
    vecs[7]  = '{1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 32'h0,         1'b1};
    vecs[8]  = '{1'b1, 32'h8000_1000, 32'h5555_5555, 4'hF, 32'h0,         1'b1};
    vecs[9]  = '{1'b0, 32'h8000_0FFC, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0};
    vecs[10] = '{1'b1, 32'h8000_0030, 32'h0102_0304, 4'hF, 32'h0,         1'b0};
    vecs[11] = '{1'b1, 32'h8000_0030, 32'hA5A5_A5A5, 4'h0, 32'h0,         1'b0};
    vecs[12] = '{1'b0, 32'h8000_0030, 32'h0,         4'h0, 32'h0102_0304, 1'b0};
    vecs[13] = '{1'b0, 32'h8000_0023, 32'h0,         4'h0, 32'h11BB_33AA, 1'b0};
    vecs[14] = '{1'b1, 32'h8000_0000, 32'h0F0F_0F0F, 4'hF, 32'h0,         1'b0};
    vecs[15] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'h0,         1'b1};

    $display("[TB] reset state");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
    checkOutput("rst_resp_err", 32'(resp_err), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] latency of LATENCY=1/2/15 builds");
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = BASE;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat1 = 0; lat2 = 0; lat15 = 0;
    for (int t = 1; t <= 20; t++) begin
      @(posedge clk); #1;
      if (l1_valid && lat1 == 0) lat1 = t;
      if (resp_valid && lat2 == 0) lat2 = t;
      if (l15_valid && lat15 == 0) lat15 = t;
    end
    checkOutput("lat_build1", 32'(lat1), 32'd1);
    checkOutput("lat_build2", 32'(lat2), 32'd2);
    checkOutput("lat_build15", 32'(lat15), 32'd15);
    checkOutput("err_build1", 32'(l1_err), 32'd0);
    checkOutput("err_build15", 32'(l15_err), 32'd0);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checkOutput("idle_after_lat", 32'(req_ready), 32'd1);

    $display("[TB] directed vector table");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].wmask, i % 3, rdata, err, lat);
      modelUpdate(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].wmask, exp_rdata, exp_err);
      checkOutput($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      checkOutput($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
      checkOutput($sformatf("vec%0d_lat", i), 32'(lat), 32'd2);
    end

    $display("[TB] backpressure and back-to-back acceptance");
    applyStimulus(1'b1, 32'h8000_0040, 32'h600D_F00D, 4'hF, 0, rdata, err, lat);
    modelUpdate(1'b1, 32'h8000_0040, 32'h600D_F00D, 4'hF, exp_rdata, exp_err);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h8000_0040;
    @(posedge clk); #1;
    req_write = 1'b1;
    req_wdata = 32'hBAD0_BAD0;
    req_wmask = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("bp%0d_valid", i), 32'(resp_valid), 32'd1);
      checkOutput($sformatf("bp%0d_rdata", i), resp_rdata, 32'h600D_F00D);
      checkOutput($sformatf("bp%0d_err", i), 32'(resp_err), 32'd0);
      checkOutput($sformatf("bp%0d_req_ready", i), 32'(req_ready), 32'd0);
      if (i < 5) begin
        @(posedge clk); #1;
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checkOutput("bp_handshake_valid", 32'(resp_valid), 32'd0);
    checkOutput("bp_ready_after", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("bp_next_accepted", 32'(req_ready), 32'd0);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!resp_valid && lat < 40);
    checkOutput("bp_next_lat", 32'(lat), 32'd2);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    modelUpdate(1'b1, 32'h8000_0040, 32'hBAD0_BAD0, 4'hF, exp_rdata, exp_err);
    applyStimulus(1'b0, 32'h8000_0040, 32'h0, 4'h0, 0, rdata, err, lat);
    checkOutput("bp_store_landed", rdata, 32'hBAD0_BAD0);

    $display("[TB] reset during BUSY aborts pending store");
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h8000_0010;
    req_wdata = 32'h1234_5678;
    req_wmask = 4'hF;
    waitc = 0;
    while (!req_ready && waitc < 50) begin
      @(posedge clk); #1;
      waitc++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("abort_req_ready", 32'(req_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_ready_after", 32'(req_ready), 32'd1);
    modelUpdate(1'b0, 32'h8000_0010, 32'h0, 4'h0, exp_rdata, exp_err);
    applyStimulus(1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, rdata, err, lat);
    checkOutput("abort_pre_store_value", rdata, exp_rdata);
    checkOutput("abort_pre_store_const", rdata, 32'hDEAD_BEEF);

    $display("[TB] random traffic against reference model");
    for (int n = 0; n < 60; n++) begin
      bit [31:0] a;
      bit [31:0] d;
      bit [3:0]  m;
      bit        w;
      int        kind;
      kind = int'($urandom_range(0, 9));
      d = $urandom;
      m = 4'($urandom);
      w = 1'($urandom);
      if (kind < 2) begin
        case ($urandom_range(0, 3))
          0: a = BASE - 32'(4 * $urandom_range(1, 64));
          1: a = BASE + SPAN + 32'(4 * $urandom_range(0, 64));
          2: a = 32'hFFFF_FFFC;
          default: a = 32'h0;
        endcase
      end else begin
        a = BASE + 32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
        if (!ref_mem.exists({a[31:2], 2'b00})) begin
          w = 1'b1;
          m = 4'hF;
        end
      end
      modelUpdate(w, a, d, m, exp_rdata, exp_err);
      applyStimulus(w, a, d, m, int'($urandom_range(0, 3)), rdata, err, lat);
      checkOutput($sformatf("rnd%0d_rdata", n), rdata, exp_rdata);
      checkOutput($sformatf("rnd%0d_err", n), 32'(err), 32'(exp_err));
      checkOutput($sformatf("rnd%0d_lat", n), 32'(lat), 32'd2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
